// File: rtl/mem_inst_responder.sv
// Instruction-fetch responder: reads 2 (RVC) or 4 bytes little-endian from a
// byte-wide synchronous RAM and returns them as a one-beat response.
module mem_inst_responder #(
   parameter int XLEN   = 32,
   parameter int RAM_AW = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              icache_mem_enable,
   input  logic [XLEN-1:0]   icache_inst_addr,
   input  logic [7:0]        ram_din,
   output logic [RAM_AW-1:0] ram_a,
   output logic              ram_wr,
   output logic              mem_busy,
   output logic              mem_inst_ready,
   output logic [XLEN-1:0]   mem_inst,
   output logic [XLEN-1:0]   mem_inst_addr
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]        state;
   logic [2:0]        cnt;
   logic              is_wide;
   logic [XLEN-1:0]   addr_q;
   logic [RAM_AW-1:0] base_a;

   assign ram_wr = 1'b0;

   // cnt counts edges after the accept edge; each RAM byte arrives one edge
   // after its address, so byte k lands when cnt == k+1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         cnt            <= 3'd0;
         is_wide        <= 1'b0;
         addr_q         <= '0;
         base_a         <= '0;
         ram_a          <= '0;
         mem_busy       <= 1'b0;
         mem_inst_ready <= 1'b0;
         mem_inst       <= '0;
         mem_inst_addr  <= '0;
      end else if (flush) begin
         state          <= ST_IDLE;
         mem_busy       <= 1'b0;
         mem_inst_ready <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (icache_mem_enable) begin
                  state    <= ST_FETCH;
                  addr_q   <= icache_inst_addr;
                  base_a   <= RAM_AW'(icache_inst_addr);
                  ram_a    <= RAM_AW'(icache_inst_addr);
                  mem_busy <= 1'b1;
                  cnt      <= 3'd0;
               end
            end
            ST_FETCH: begin
               cnt <= cnt + 3'd1;
               case (cnt)
                  3'd0: ram_a <= base_a + RAM_AW'(1);
                  3'd1: begin
                     // Low two bits of byte0 decide between RVC and 32-bit.
                     mem_inst[7:0] <= ram_din;
                     is_wide       <= &ram_din[1:0];
                     if (&ram_din[1:0])
                        ram_a <= base_a + RAM_AW'(2);
                  end
                  3'd2: begin
                     if (!is_wide) begin
                        mem_inst       <= XLEN'({ram_din, mem_inst[7:0]});
                        mem_inst_ready <= 1'b1;
                        mem_inst_addr  <= addr_q;
                        state          <= ST_DONE;
                     end else begin
                        mem_inst[15:8] <= ram_din;
                        ram_a          <= base_a + RAM_AW'(3);
                     end
                  end
                  3'd3: mem_inst[23:16] <= ram_din;
                  default: begin
                     mem_inst       <= XLEN'({ram_din, mem_inst[23:0]});
                     mem_inst_ready <= 1'b1;
                     mem_inst_addr  <= addr_q;
                     state          <= ST_DONE;
                  end
               endcase
            end
            ST_DONE: begin
               if (!stall) begin
                  mem_inst_ready <= 1'b0;
                  mem_busy       <= 1'b0;
                  state          <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_inst_responder.md
Name: mem_inst_responder

Overview:
- Memory-side responder for instruction-fetch requests issued by the instruction cache (icache_mem_enable / icache_inst_addr).
- Reads instruction bytes from the byte-wide synchronous RAM, little-endian.
- Fetches 2 bytes for a compressed (RVC) instruction and 4 bytes otherwise.
- Returns the result as a one-beat mem_inst_ready / mem_inst / mem_inst_addr response. Signals occupancy on mem_busy.

Parameters:
- XLEN, 32, data/address width of request and response.
- RAM_AW, 32, width of RAM byte address.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; aborts any in-flight fetch.
- stall  in  1  consumer stalled; holds a completed response.
- icache_mem_enable  in  1  fetch request valid (level).
- icache_inst_addr  in  XLEN  fetch byte address (2-byte aligned).
- ram_din  in  8  RAM read byte, valid the cycle after ram_a is presented.
- ram_a  out  RAM_AW  RAM byte address (registered).
- ram_wr  out  1  RAM write enable; constant 0 (read-only port).
- mem_busy  out  1  responder not idle.
- mem_inst_ready  out  1  response valid.
- mem_inst  out  XLEN  fetched instruction; upper 16 bits zero for RVC.
- mem_inst_addr  out  XLEN  address of the fetched instruction.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; ram_a=0; ram_wr=0; mem_busy=0; mem_inst_ready=0; mem_inst=0; mem_inst_addr=0; byte counter=0.
- States: IDLE, FETCH, DONE.
- IDLE → FETCH at posedge when icache_mem_enable=1 and flush=0 (accept edge E0):
  - latch addr A; ram_a<=A; mem_busy<=1; cnt<=0.
- FETCH pipelines one address per cycle.
  - A+k is driven during cycle k+1 (ram_a<=A+1 at E1).
  - byte k is sampled from ram_din at edge E(k+2) into mem_inst[8k+7:8k].
- Width decision at E2, when byte0 is sampled:
  - byte0[1:0]!=2'b11: ram_a holds A+1; total 2 bytes. At E3, after sampling byte1: mem_inst[31:16]<=0, mem_inst_ready<=1, state→DONE.
  - byte0[1:0]==2'b11: ram_a<=A+2, then A+3 at E3; total 4 bytes. At E5, after sampling byte3: mem_inst_ready<=1, state→DONE.
- Latency (accept edge to ready visible): 3 cycles for RVC, 5 cycles for 32-bit.
- mem_inst_addr<=A when ready is raised.
- DONE:
  - mem_inst_ready=1 and mem_busy=1.
  - If stall=0 at posedge: clear ready, mem_busy<=0, state→IDLE. The pulse is exactly 1 cycle when unstalled.
  - If stall=1: hold ready and data unchanged.
  - No new request is accepted in DONE. The earliest next accept is the edge after IDLE is re-entered.
- mem_busy is 1 in FETCH and DONE, 0 only in IDLE.
- flush=1 at any posedge (priority over everything except reset):
  - state→IDLE; mem_busy<=0; mem_inst_ready<=0; no response is emitted for the aborted fetch.
  - icache_mem_enable in the same cycle is ignored.
- Address arithmetic is modulo 2^RAM_AW; A+k wraps at the top of the address space.
- A request held high after completion is re-served (repeat fetch is legal).
- Changes on icache_inst_addr during FETCH are ignored (A latched).
- ram_din is ignored outside the sampling edges defined above.

Test Plan:
- Reset mid-FETCH:
  - Stimulus: assert rst_n=0 two cycles after accept.
  - Required: all outputs 0 immediately (async); no ready after release; next request served normally.
- RVC fetch:
  - Stimulus: RAM[0x100]=0x01, RAM[0x101]=0x45; request A=0x100.
  - Required: ram_a sequence 0x100, 0x101; ready high exactly cycle 3 after accept; mem_inst=0x00004501; mem_inst_addr=0x100; mem_busy low next cycle.
- 32-bit fetch:
  - Stimulus: RAM[0x200..0x203]=0x13,0x05,0x10,0x00; A=0x200.
  - Required: ram_a 0x200..0x203; ready at cycle 5; mem_inst=0x00100513.
- Stall hold:
  - Stimulus: 32-bit fetch with stall=1 for 3 cycles from ready.
  - Required: ready and mem_inst stable 4 cycles, mem_busy=1 throughout; IDLE after stall drops.
- Flush abort:
  - Stimulus: flush=1 at E3 of a 32-bit fetch, with icache_mem_enable=1 in that cycle.
  - Required: no ready pulse; mem_busy=0 next cycle; request re-accepted the following edge.
- Wrap-around:
  - Stimulus: A=0xFFFFFFFE, 32-bit instruction.
  - Required: ram_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; mem_inst assembled in that byte order.
